// File: rtl/ecc2d_pkg.sv
// Shared definitions for the 2D-ECC encoder/decoder pair.
// Data is a ROWS x COLS matrix (bit i -> row i/COLS, col i%COLS) with even parity.
package ecc2d_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 8;

  // Parity helpers work on a fixed maximal footprint so one function serves every geometry.
  localparam int PAR_MAX_W   = 256;
  localparam int PAR_MAX_DIM = 32;
  localparam int PAR_DIM_IW  = $clog2(PAR_MAX_DIM);
  localparam int PAR_W_IW    = $clog2(PAR_MAX_W);

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DATA1,
    ERR_PAR1,
    ERR_DOUBLE
  } err_class_t;

  function automatic logic [PAR_MAX_DIM-1:0] row_parity(
    input logic [PAR_MAX_W-1:0] data,
    input int                   rows,
    input int                   cols
  );
    logic [PAR_MAX_DIM-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < rows * cols) begin
        p[PAR_DIM_IW'(i / cols)] = p[PAR_DIM_IW'(i / cols)] ^ data[PAR_W_IW'(i)];
      end
    end
    return p;
  endfunction

  function automatic logic [PAR_MAX_DIM-1:0] col_parity(
    input logic [PAR_MAX_W-1:0] data,
    input int                   rows,
    input int                   cols
  );
    logic [PAR_MAX_DIM-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < rows * cols) begin
        p[PAR_DIM_IW'(i % cols)] = p[PAR_DIM_IW'(i % cols)] ^ data[PAR_W_IW'(i)];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc2d_syndrome.sv
// Combinational row/column syndrome: received parity XOR parity recomputed from data.
// Used by both the decoder and the encoder.
module ecc2d_syndrome
  import ecc2d_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [ROWS*COLS-1:0] i_data,
  input  logic [ROWS-1:0]      i_row_par,
  input  logic [COLS-1:0]      i_col_par,
  output logic [ROWS-1:0]      o_rs,
  output logic [COLS-1:0]      o_cs
);

  logic [PAR_MAX_W-1:0]   w_data_ext;
  logic [PAR_MAX_DIM-1:0] w_row_calc;
  logic [PAR_MAX_DIM-1:0] w_col_calc;
  logic                   w_unused_calc;

  assign w_data_ext = PAR_MAX_W'(i_data);
  assign w_row_calc = row_parity(w_data_ext, ROWS, COLS);
  assign w_col_calc = col_parity(w_data_ext, ROWS, COLS);

  assign o_rs = i_row_par ^ w_row_calc[ROWS-1:0];
  assign o_cs = i_col_par ^ w_col_calc[COLS-1:0];

  // Upper bits of the generic helpers are always zero for this geometry.
  assign w_unused_calc = ^{w_row_calc, w_col_calc};

endmodule

// File: rtl/ecc2d_decoder.sv
// 2D-parity SECDED decoder: syndrome stage, classify/correct stage, valid/ready
// pipeline, saturating error counters and a sticky double-error interrupt.
module ecc2d_decoder
  import ecc2d_pkg::*;
#(
  parameter  int ROWS  = ROWS_DEF,
  parameter  int COLS  = COLS_DEF,
  parameter  int CNT_W = 16,
  localparam int WIDTH = ROWS * COLS,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [ROWS-1:0]  in_row_par,
  input  logic [COLS-1:0]  in_col_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err_single,
  output logic             out_par_err,
  output logic             out_err_double,
  output logic [POS_W-1:0] out_err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt,
  output logic             irq_double
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [ROWS-1:0]  r_s1_rs;
  logic [COLS-1:0]  r_s1_cs;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_single;
  logic             r_out_par_err;
  logic             r_out_double;
  logic [POS_W-1:0] r_out_pos;

  logic [CNT_W-1:0] r_single_cnt;
  logic [CNT_W-1:0] r_double_cnt;
  logic             r_irq_double;

  logic [ROWS-1:0]  w_rs;
  logic [COLS-1:0]  w_cs;
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_deliver;
  logic [WIDTH-1:0] w_flip_mask;
  logic [POS_W-1:0] w_flip_pos;
  err_class_t       w_class;

  ecc2d_syndrome #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_syndrome (
    .i_data    (in_data),
    .i_row_par (in_row_par),
    .i_col_par (in_col_par),
    .o_rs      (w_rs),
    .o_cs      (w_cs)
  );

  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = rst_n && w_s1_adv;
  assign w_deliver = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_rs    <= '0;
      r_s1_cs    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_rs   <= w_rs;
        r_s1_cs   <= w_cs;
      end
    end
  end

  // Outer product of the syndromes: exactly one bit set when one row and one column disagree.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign w_flip_mask[gi] = r_s1_rs[gi / COLS] & r_s1_cs[gi % COLS];
  end

  // One-hot to binary: each position bit ORs the mask bits whose index has that bit set.
  for (genvar gb = 0; gb < POS_W; gb++) begin : g_enc
    logic [WIDTH-1:0] w_sel;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_sel[gi] = (((gi >> gb) & 1) != 0) ? w_flip_mask[gi] : 1'b0;
    end
    assign w_flip_pos[gb] = |w_sel;
  end

  always_comb begin
    w_class = ERR_DOUBLE;
    if (r_s1_rs == '0 && r_s1_cs == '0) begin
      w_class = ERR_NONE;
    end else if ($onehot(r_s1_rs) && $onehot(r_s1_cs)) begin
      w_class = ERR_DATA1;
    end else if (($onehot(r_s1_rs) && r_s1_cs == '0) || (r_s1_rs == '0 && $onehot(r_s1_cs))) begin
      w_class = ERR_PAR1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_single  <= 1'b0;
      r_out_par_err <= 1'b0;
      r_out_double  <= 1'b0;
      r_out_pos     <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data    <= (w_class == ERR_DATA1) ? (r_s1_data ^ w_flip_mask) : r_s1_data;
        r_out_single  <= (w_class == ERR_DATA1) || (w_class == ERR_PAR1);
        r_out_par_err <= (w_class == ERR_PAR1);
        r_out_double  <= (w_class == ERR_DOUBLE);
        r_out_pos     <= (w_class == ERR_DATA1) ? w_flip_pos : '0;
      end
    end
  end

  // Clear takes priority over a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
      r_irq_double <= 1'b0;
    end else if (cnt_clr) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
      r_irq_double <= 1'b0;
    end else if (w_deliver) begin
      if (r_out_single && r_single_cnt != '1) begin
        r_single_cnt <= r_single_cnt + CNT_W'(1);
      end
      if (r_out_double) begin
        if (r_double_cnt != '1) begin
          r_double_cnt <= r_double_cnt + CNT_W'(1);
        end
        r_irq_double <= 1'b1;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_err_single = r_out_single;
  assign out_par_err    = r_out_par_err;
  assign out_err_double = r_out_double;
  assign out_err_pos    = r_out_pos;
  assign single_cnt     = r_single_cnt;
  assign double_cnt     = r_double_cnt;
  assign irq_double     = r_irq_double;

endmodule
